// File: rtl/rggen_apb_pkg.sv
// Shared types and helpers for the rggen APB master bridge.
package rggen_apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESPONSE
    } rggen_apb_master_state_e;

    // Number of byte-offset address bits that paddr forces to zero.
    function automatic int unsigned calc_addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/rggen_apb_if.sv
// APB4 bus bundle shared by the bridge (master) and register blocks (slave).
interface rggen_apb_if #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned BUS_WIDTH     = 32
);
    logic                     psel;
    logic                     penable;
    logic [ADDRESS_WIDTH-1:0] paddr;
    logic [2:0]               pprot;
    logic                     pwrite;
    logic [BUS_WIDTH/8-1:0]   pstrb;
    logic [BUS_WIDTH-1:0]     pwdata;
    logic                     pready;
    logic [BUS_WIDTH-1:0]     prdata;
    logic                     pslverr;

    modport master (
        output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/rggen_apb_timeout_counter.sv
// Counts ACCESS cycles and flags the last permitted cycle before an abort.
module rggen_apb_timeout_counter #(
    parameter int unsigned CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int unsigned   W    = $clog2(CYCLES + 1);
    localparam logic [W-1:0]  LAST = W'(CYCLES - 1);
    localparam logic [W-1:0]  MAX  = W'(CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

    assign o_expired = i_enable && (count == LAST);
endmodule

// File: rtl/rggen_apb_master_bridge.sv
// Valid/ready command stream to APB4 master bridge, one transfer in flight,
// with an optional ACCESS-phase timeout.
module rggen_apb_master_bridge
    import rggen_apb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [2:0]  PPROT_VALUE    = 3'b000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_write,
    input  logic [ADDRESS_WIDTH-1:0] i_req_address,
    input  logic [DATA_WIDTH-1:0]    i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0]  i_req_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [DATA_WIDTH-1:0]    o_rsp_rdata,
    output logic                     o_rsp_error,
    output logic                     o_rsp_timeout,
    rggen_apb_if.master              apb_if
);
    localparam int unsigned              ADDR_LSB  = calc_addr_lsb(DATA_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = '1 << ADDR_LSB;

    rggen_apb_master_state_e state, state_next;

    logic                     write_q;
    logic [ADDRESS_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0]    pwdata_q;
    logic [DATA_WIDTH/8-1:0]  pstrb_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     error_q;
    logic                     timeout_q;
    logic                     timeout_expired;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            rggen_apb_timeout_counter #(
                .CYCLES (TIMEOUT_CYCLES)
            ) u_timeout_counter (
                .clk       (clk),
                .rst       (rst),
                .i_clear   (state == SETUP),
                .i_enable  (state == ACCESS),
                .o_expired (timeout_expired)
            );
        end else begin : g_no_timeout
            assign timeout_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (i_req_valid)                        state_next = SETUP;
            SETUP:                                             state_next = ACCESS;
            ACCESS:   if (apb_if.pready || timeout_expired)   state_next = RESPONSE;
            RESPONSE: if (i_rsp_ready)                        state_next = IDLE;
            default:                                           state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q   <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if ((state == IDLE) && i_req_valid) begin
                write_q  <= i_req_write;
                paddr_q  <= i_req_address & ADDR_MASK;
                pwdata_q <= i_req_write ? i_req_wdata  : '0;
                pstrb_q  <= i_req_write ? i_req_strobe : '0;
            end
            // pready takes priority over an expiring timeout in the same cycle.
            if (state == ACCESS) begin
                if (apb_if.pready) begin
                    error_q   <= apb_if.pslverr;
                    timeout_q <= 1'b0;
                    rdata_q   <= (!write_q && !apb_if.pslverr) ? apb_if.prdata : '0;
                end else if (timeout_expired) begin
                    error_q   <= 1'b1;
                    timeout_q <= 1'b1;
                    rdata_q   <= '0;
                end
            end
        end
    end

    // Bus controls decode straight from the state flops, so reset clears them at once.
    assign apb_if.psel    = (state == SETUP) || (state == ACCESS);
    assign apb_if.penable = (state == ACCESS);
    assign apb_if.paddr   = paddr_q;
    assign apb_if.pwrite  = write_q;
    assign apb_if.pwdata  = pwdata_q;
    assign apb_if.pstrb   = pstrb_q;
    assign apb_if.pprot   = PPROT_VALUE;

    assign o_req_ready   = (state == IDLE);
    assign o_rsp_valid   = (state == RESPONSE);
    assign o_rsp_rdata   = rdata_q;
    assign o_rsp_error   = error_q;
    assign o_rsp_timeout = timeout_q;
endmodule

// File: tb/tb_rggen_apb_master_bridge.sv
// Self-checking bench for rggen_apb_master_bridge: directed cases plus random transfers.
module tb_rggen_apb_master_bridge;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_strobe = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int txn_id = 0;

    rggen_apb_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) apb_bus ();

    rggen_apb_master_bridge #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .PPROT_VALUE    (3'b010)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_write   (req_write),
        .i_req_address (req_address),
        .i_req_wdata   (req_wdata),
        .i_req_strobe  (req_strobe),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_error   (rsp_error),
        .o_rsp_timeout (rsp_timeout),
        .apb_if        (apb_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s (txn %0d): observed=0x%0h expected=0x%0h", tag, txn_id, obs, exp);
        end
    endtask

    // Drives one request and plays the slave; wait_n = pready-low cycles before pready.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [3:0] strb, input int wait_n, input bit slverr,
                           input logic [DW-1:0] prdata, input int rsp_delay);
        logic [AW-1:0] e_paddr;
        logic [DW-1:0] e_pwdata, e_rdata;
        logic [3:0]    e_pstrb;
        bit            e_to, e_err;
        int            e_cycles, cyc;

        e_paddr  = addr & ~AW'(3);
        e_pwdata = wr ? wdata : '0;
        e_pstrb  = wr ? strb : 4'h0;
        e_to     = (wait_n >= int'(TO));
        e_cycles = e_to ? int'(TO) : wait_n + 1;
        e_err    = e_to ? 1'b1 : slverr;
        e_rdata  = (!wr && !e_err) ? prdata : '0;
        txn_id++;

        req_valid = 1'b1; req_write = wr; req_address = addr; req_wdata = wdata; req_strobe = strb;
        check("idle.req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~wr;
        req_address = AW'($urandom); req_wdata = $urandom; req_strobe = 4'($urandom);

        check("setup.psel", apb_bus.psel, 1);
        check("setup.penable", apb_bus.penable, 0);
        check("setup.paddr", apb_bus.paddr, e_paddr);
        check("setup.pwrite", apb_bus.pwrite, wr);
        check("setup.pwdata", apb_bus.pwdata, e_pwdata);
        check("setup.pstrb", apb_bus.pstrb, e_pstrb);
        check("setup.pprot", apb_bus.pprot, 3'b010);
        check("setup.req_ready", req_ready, 0);
        check("setup.rsp_valid", rsp_valid, 0);

        apb_bus.prdata = prdata; apb_bus.pslverr = slverr;
        @(posedge clk); #1;
        cyc = 0;
        while (apb_bus.penable === 1'b1 && cyc < 20) begin
            check("access.psel", apb_bus.psel, 1);
            check("access.paddr", apb_bus.paddr, e_paddr);
            check("access.pwdata", apb_bus.pwdata, e_pwdata);
            apb_bus.pready = (cyc == wait_n);
            cyc++;
            @(posedge clk); #1;
        end
        apb_bus.pready = 1'b0;
        apb_bus.prdata = $urandom; apb_bus.pslverr = 1'($urandom);
        check("access.cycles", 64'(cyc), 64'(e_cycles));

        check("rsp.valid", rsp_valid, 1);
        check("rsp.psel", apb_bus.psel, 0);
        check("rsp.error", rsp_error, e_err);
        check("rsp.timeout", rsp_timeout, e_to);
        check("rsp.rdata", rsp_rdata, e_rdata);
        check("rsp.req_ready", req_ready, 0);

        for (int d = 0; d < rsp_delay; d++) begin
            req_valid = 1'b1; req_address = AW'($urandom);
            @(posedge clk); #1;
            check("hold.valid", rsp_valid, 1);
            check("hold.rdata", rsp_rdata, e_rdata);
            check("hold.error", rsp_error, e_err);
            check("hold.req_ready", req_ready, 0);
            check("hold.psel", apb_bus.psel, 0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("done.rsp_valid", rsp_valid, 0);
        check("done.req_ready", req_ready, 1);
        check("done.paddr_kept", apb_bus.paddr, e_paddr);
    endtask

    initial begin
        apb_bus.pready = 1'b0; apb_bus.prdata = '0; apb_bus.pslverr = 1'b0;
        #1;
        check("reset.req_ready", req_ready, 1);
        check("reset.rsp_valid", rsp_valid, 0);
        check("reset.psel", apb_bus.psel, 0);
        check("reset.penable", apb_bus.penable, 0);
        check("reset.paddr", apb_bus.paddr, 0);
        check("reset.pwdata", apb_bus.pwdata, 0);
        check("reset.rsp_error", rsp_error, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_txn(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0BAD_F00D, 0);
        run_txn(1'b0, 16'h0013, 32'h0, 4'hF, 3, 1'b0, 32'h12345678, 0);
        run_txn(1'b0, 16'h0020, 32'h0, 4'h0, 1, 1'b1, 32'hFFFF_FFFF, 0);
        run_txn(1'b0, 16'h0040, 32'h0, 4'h0, 50, 1'b0, 32'hA5A5_A5A5, 1);
        run_txn(1'b1, 16'h0043, 32'h1357_9BDF, 4'h5, 50, 1'b0, 32'h0, 0);
        run_txn(1'b1, 16'h0102, 32'hCAFE_0001, 4'h3, 2, 1'b0, 32'h7777_7777, 5);

        // Reset mid-ACCESS: bus controls drop at once and no response follows.
        req_valid = 1'b1; req_write = 1'b0; req_address = 16'h0080;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort.penable_before", apb_bus.penable, 1);
        #2 rst = 1'b1;
        #1;
        check("abort.psel", apb_bus.psel, 0);
        check("abort.penable", apb_bus.penable, 0);
        check("abort.rsp_valid", rsp_valid, 0);
        check("abort.req_ready", req_ready, 1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("abort.no_rsp", rsp_valid, 0);
        run_txn(1'b0, 16'h0084, 32'h0, 4'h0, 0, 1'b0, 32'h0F0F_1234, 0);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), AW'($urandom), $urandom, 4'($urandom),
                    int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0),
                    $urandom, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
